// File: rtl/alu_ex_mem_stage.sv
// EX->MEM pipeline boundary: registers the ALU result and control bits behind a
// two-entry skid buffer and resolves branches into a one-cycle PC redirect pulse.
module alu_ex_mem_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  input  logic          alu_g,
  input  logic          alu_e,
  input  logic [2:0]    br_op,
  input  logic [DW-1:0] pc_plus4,
  input  logic [DW-1:0] br_offset,
  input  logic [RW-1:0] rd_in,
  input  logic [2:0]    ctl_in,
  input  logic [DW-1:0] store_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic [2:0]    flags,
  output logic [RW-1:0] rd_out,
  output logic [2:0]    ctl_out,
  output logic [DW-1:0] store_out,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc
);

  localparam int unsigned FW = 3;
  localparam int unsigned CW = 3;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGT  = 3'b011;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLE  = 3'b110;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [FW-1:0] flg;
    logic [RW-1:0] rd;
    logic [CW-1:0] ctl;
    logic [DW-1:0] st;
  } entry_t;

  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            redirect_q, redirect_d;
  logic [DW-1:0]   redirect_pc_q, redirect_pc_d;

  entry_t          in_word_c;
  logic            accept_c;
  logic            drain_c;
  logic            taken_c;
  logic [DW-1:0]   target_c;

  // Incoming word packing and handshake qualifiers.
  always_comb begin
    in_word_c.res = alu_out;
    in_word_c.flg = {alu_cout, alu_g, alu_e};
    in_word_c.rd  = rd_in;
    in_word_c.ctl = ctl_in;
    in_word_c.st  = store_in;
    accept_c      = in_valid & in_ready_q & ~flush;
    drain_c       = main_valid_q & out_ready;
  end

  // Branch condition from the ALU compare flags, and the wrapping target adder.
  always_comb begin
    taken_c = 1'b0;
    case (br_op)
      BR_NONE: taken_c = 1'b0;
      BR_BEQ:  taken_c = alu_e;
      BR_BNE:  taken_c = ~alu_e;
      BR_BGT:  taken_c = alu_g;
      BR_BLT:  taken_c = ~alu_g & ~alu_e;
      BR_BGE:  taken_c = alu_g | alu_e;
      BR_BLE:  taken_c = ~alu_g;
      default: taken_c = 1'b1;
    endcase
    target_c = pc_plus4 + (br_offset << 2);
  end

  // Main/skid next state; the skid always drains into main before new input.
  always_comb begin
    main_d        = main_q;
    main_valid_d  = main_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    redirect_d    = accept_c & taken_c;
    redirect_pc_d = redirect_pc_q;

    if (!main_valid_q || drain_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_d       = in_word_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = in_word_c;
      skid_valid_d = 1'b1;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    if (redirect_d) begin
      redirect_pc_d = target_c;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      main_q        <= main_d;
      skid_q        <= skid_d;
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign result      = main_q.res;
  assign flags       = main_q.flg;
  assign rd_out      = main_q.rd;
  assign ctl_out     = main_q.ctl;
  assign store_out   = main_q.st;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule
